// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer with in-order alloc/commit, multi-channel writeback,
// dual operand bypass and a one-cycle flush after a taken-branch commit.
module rob_param #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int NUM_WB = 3,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [4:0]               alloc_dest,
  input  logic [2:0]               alloc_type,
  input  logic                     alloc_done,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB-1:0]        wb_jump,
  input  logic [NUM_WB*DATA_W-1:0] wb_target,
  input  logic [TAG_W-1:0]         q1_tag,
  input  logic [TAG_W-1:0]         q2_tag,
  output logic                     q1_hit,
  output logic                     q2_hit,
  output logic [DATA_W-1:0]        q1_data,
  output logic [DATA_W-1:0]        q2_data,
  output logic                     commit_valid,
  output logic [4:0]               commit_dest,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [DATA_W-1:0]        commit_data,
  output logic                     lsb_commit,
  output logic                     redirect_valid,
  output logic [DATA_W-1:0]        redirect_pc,
  output logic                     flush,
  output logic [TAG_W:0]           count
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [TAG_W-1:0] head, tail;
  logic [DEPTH-1:0] live, ready, jump_q;
  logic [4:0] dest_q [DEPTH];
  logic [2:0] type_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] target_q [DEPTH];
  logic do_alloc, do_commit, taken;
  logic [2:0] h_type;
  assign alloc_ready = (state == RUN) && (count != (TAG_W+1)'(DEPTH));
  assign alloc_tag = tail;
  assign do_alloc = rdy && alloc_valid && alloc_ready;
  assign do_commit = rdy && (state == RUN) && (count != '0) && ready[head];
  assign h_type = type_q[head];
  assign taken = (h_type == 3'd1 || h_type == 3'd2) && jump_q[head];
  // Stored ready data takes precedence; otherwise the lowest-index matching writeback forwards.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
    lookup = (live[t] && ready[t]) ? {1'b1, data_q[t]} : '0;
    for (int i = NUM_WB-1; i >= 0; i--)
      if (!(live[t] && ready[t]) && wb_valid[i] && wb_tag[i*TAG_W +: TAG_W] == t)
        lookup = {1'b1, wb_data[i*DATA_W +: DATA_W]};
  endfunction
  always_comb begin
    {q1_hit, q1_data} = lookup(q1_tag);
    {q2_hit, q2_data} = lookup(q2_tag);
  end
  always_ff @(posedge clk) begin
    if (rdy && state == RUN) begin
      for (int i = 0; i < NUM_WB; i++)
        if (wb_valid[i] && live[wb_tag[i*TAG_W +: TAG_W]]) begin
          data_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_data[i*DATA_W +: DATA_W];
          target_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_target[i*DATA_W +: DATA_W];
        end
      if (do_alloc) begin
        dest_q[tail] <= alloc_dest;
        type_q[tail] <= alloc_type;
        data_q[tail] <= '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      head <= '0;
      tail <= '0;
      count <= '0;
      live <= '0;
      ready <= '0;
      jump_q <= '0;
      commit_valid <= 1'b0;
      commit_dest <= '0;
      commit_tag <= '0;
      commit_data <= '0;
      lsb_commit <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      flush <= 1'b0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      lsb_commit <= 1'b0;
      redirect_valid <= 1'b0;
      flush <= 1'b0;
    end else if (state == FLUSH) begin
      commit_valid <= 1'b0;
      lsb_commit <= 1'b0;
      redirect_valid <= 1'b0;
      flush <= 1'b1;
      head <= '0;
      tail <= '0;
      count <= '0;
      live <= '0;
      ready <= '0;
      state <= RUN;
    end else begin
      commit_valid <= 1'b0;
      lsb_commit <= 1'b0;
      redirect_valid <= 1'b0;
      flush <= 1'b0;
      for (int i = 0; i < NUM_WB; i++)
        if (wb_valid[i] && live[wb_tag[i*TAG_W +: TAG_W]]) begin
          ready[wb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
          jump_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_jump[i];
        end
      if (do_alloc) begin
        live[tail] <= 1'b1;
        ready[tail] <= alloc_done;
        jump_q[tail] <= 1'b0;
        tail <= tail + 1'b1;
      end
      if (do_commit) begin
        head <= head + 1'b1;
        live[head] <= 1'b0;
        ready[head] <= 1'b0;
        commit_valid <= (h_type == 3'd0) || (h_type == 3'd2) || (h_type == 3'd4);
        lsb_commit <= (h_type == 3'd3) || (h_type == 3'd4);
        commit_dest <= dest_q[head];
        commit_tag <= head;
        commit_data <= data_q[head];
        if (taken) begin
          redirect_valid <= 1'b1;
          redirect_pc <= target_q[head];
          state <= FLUSH;
        end
      end
      count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
    end
  end
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed scenario bench for rob_param.
module tb_rob_param;
  logic clk = 0, rst = 0, rdy = 1;
  logic alloc_valid = 0, alloc_ready, alloc_done = 0;
  logic [3:0] alloc_tag;
  logic [4:0] alloc_dest = 0;
  logic [2:0] alloc_type = 0;
  logic [2:0] wb_valid = 0, wb_jump = 0;
  logic [11:0] wb_tag = 0;
  logic [95:0] wb_data = 0, wb_target = 0;
  logic [3:0] q1_tag = 0, q2_tag = 0;
  logic q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic commit_valid, lsb_commit, redirect_valid, flush;
  logic [4:0] commit_dest;
  logic [3:0] commit_tag;
  logic [31:0] commit_data, redirect_pc;
  logic [4:0] count;
  int tests = 0, fails = 0;

  rob_param dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_dest(alloc_dest), .alloc_type(alloc_type), .alloc_done(alloc_done),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_jump(wb_jump), .wb_target(wb_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_hit(q1_hit), .q2_hit(q2_hit), .q1_data(q1_data), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag), .commit_data(commit_data),
    .lsb_commit(lsb_commit), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_in();
    alloc_valid = 0; wb_valid = 0; wb_jump = 0;
  endtask

  task automatic set_wb(input int ch, input logic [3:0] t, input logic [31:0] d, input logic j, input logic [31:0] tg);
    wb_valid[ch] = 1; wb_tag[ch*4 +: 4] = t; wb_data[ch*32 +: 32] = d; wb_jump[ch] = j; wb_target[ch*32 +: 32] = tg;
  endtask

  task automatic alloc(input logic [2:0] ty, input logic [4:0] d, input logic done);
    alloc_valid = 1; alloc_type = ty; alloc_dest = d; alloc_done = done;
    cyc();
    alloc_valid = 0;
  endtask

  task automatic reset_dut();
    clr_in(); rdy = 1; rst = 0;
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    tests++; if ({commit_valid, lsb_commit, redirect_valid, flush} !== 4'b0) begin fails++; $display("FAIL reset_strobes: got %b expected 0000", {commit_valid, lsb_commit, redirect_valid, flush}); end
    rst = 1;
    alloc(0, 1, 0); alloc(0, 2, 0); alloc(0, 3, 0);
    tests++; if (count !== 5'd3) begin fails++; $display("FAIL prefill_count: got %0d expected 3", count); end
    @(posedge clk); #2 rst = 0; #1;
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL midrun_reset_count: got %0d expected 0", count); end
    tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin fails++; $display("FAIL midrun_reset_alloc: got %b/%0d expected 1/0", alloc_ready, alloc_tag); end
    tests++; if ({commit_valid, lsb_commit, redirect_valid, flush} !== 4'b0) begin fails++; $display("FAIL midrun_reset_strobes: got %b expected 0000", {commit_valid, lsb_commit, redirect_valid, flush}); end
    cyc(); rst = 1;
  endtask

  task automatic test_fill();
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      tests++; if (alloc_tag !== 4'(i)) begin fails++; $display("FAIL fill_tag: got %0d expected %0d", alloc_tag, i); end
      alloc(0, 5'(i + 1), 0);
    end
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_count: got %0d expected 16", count); end
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b expected 0", alloc_ready); end
    set_wb(0, 0, 32'h55, 0, 0);
    cyc(); clr_in();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL wb_same_cycle_commit: got %b expected 0", commit_valid); end
    cyc();
    tests++; if (commit_valid !== 1'b1 || commit_data !== 32'h55 || commit_tag !== 4'd0 || commit_dest !== 5'd1) begin fails++; $display("FAIL fill_commit: got v=%b d=%h t=%0d r=%0d expected 1/55/0/1", commit_valid, commit_data, commit_tag, commit_dest); end
    tests++; if (count !== 5'd15) begin fails++; $display("FAIL fill_commit_count: got %0d expected 15", count); end
    alloc(0, 7, 0);
    tests++; if (count !== 5'd16 || alloc_ready !== 1'b0) begin fails++; $display("FAIL refill: got %0d/%b expected 16/0", count, alloc_ready); end
    set_wb(0, 1, 32'h66, 0, 0);
    cyc(); clr_in();
    alloc_valid = 1;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_commit_ready: got %b expected 0", alloc_ready); end
    cyc(); alloc_valid = 0;
    tests++; if (count !== 5'd15 || commit_tag !== 4'd1 || commit_data !== 32'h66) begin fails++; $display("FAIL full_commit: got %0d/%0d/%h expected 15/1/66", count, commit_tag, commit_data); end
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      alloc(0, 5'(k), 0);
      set_wb(k % 3, 4'(k & 15), 32'(k + 32'h1000), 0, 0);
      cyc(); clr_in();
      cyc();
      tests++; if (commit_valid !== 1'b1 || commit_tag !== 4'(k & 15) || commit_data !== 32'(k + 32'h1000)) begin fails++; $display("FAIL wrap_commit%0d: got v=%b t=%0d d=%h expected 1/%0d/%h", k, commit_valid, commit_tag, commit_data, k & 15, k + 32'h1000); end
    end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL wrap_count: got %0d expected 0", count); end
  endtask

  task automatic test_bypass();
    reset_dut();
    for (int i = 0; i < 7; i++) alloc(0, 5'(i), 0);
    q1_tag = 5; q2_tag = 6;
    set_wb(1, 5, 32'hAB, 0, 0);
    #1;
    tests++; if (q1_hit !== 1'b1 || q1_data !== 32'hAB) begin fails++; $display("FAIL bypass_fwd: got %b/%h expected 1/ab", q1_hit, q1_data); end
    tests++; if (q2_hit !== 1'b0 || q2_data !== 32'h0) begin fails++; $display("FAIL bypass_miss: got %b/%h expected 0/0", q2_hit, q2_data); end
    cyc(); clr_in(); #1;
    tests++; if (q1_hit !== 1'b1 || q1_data !== 32'hAB) begin fails++; $display("FAIL bypass_stored: got %b/%h expected 1/ab", q1_hit, q1_data); end
    set_wb(0, 6, 32'h11, 0, 0); set_wb(2, 6, 32'h22, 0, 0); #1;
    tests++; if (q2_hit !== 1'b1 || q2_data !== 32'h11) begin fails++; $display("FAIL bypass_low_ch: got %b/%h expected 1/11", q2_hit, q2_data); end
    cyc(); clr_in(); #1;
    tests++; if (q2_hit !== 1'b1 || q2_data !== 32'h22) begin fails++; $display("FAIL wb_high_ch_wins: got %b/%h expected 1/22", q2_hit, q2_data); end
    q1_tag = 9; set_wb(0, 9, 32'h99, 0, 0); cyc(); clr_in(); #1;
    tests++; if (q1_hit !== 1'b0) begin fails++; $display("FAIL nonlive_wb_ignored: got %b expected 0", q1_hit); end
    q1_tag = 0; q2_tag = 0;
  endtask

  task automatic test_mispredict();
    reset_dut();
    alloc(1, 0, 0);
    alloc(0, 3, 1);
    set_wb(2, 0, 32'h0, 1, 32'h100);
    cyc(); clr_in();
    cyc();
    tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin fails++; $display("FAIL redirect: got %b/%h expected 1/100", redirect_valid, redirect_pc); end
    tests++; if (commit_valid !== 1'b0 || alloc_ready !== 1'b0) begin fails++; $display("FAIL redirect_side: got cv=%b ar=%b expected 0/0", commit_valid, alloc_ready); end
    cyc();
    tests++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin fails++; $display("FAIL flush: got %b/%b expected 1/0", flush, redirect_valid); end
    cyc();
    tests++; if (count !== 5'd0 || alloc_ready !== 1'b1 || flush !== 1'b0 || alloc_tag !== 4'd0) begin fails++; $display("FAIL post_flush: got c=%0d ar=%b f=%b t=%0d expected 0/1/0/0", count, alloc_ready, flush, alloc_tag); end
  endtask

  task automatic test_store_load();
    reset_dut();
    alloc(3, 0, 1);
    tests++; if (lsb_commit !== 1'b0) begin fails++; $display("FAIL store_early: got %b expected 0", lsb_commit); end
    cyc();
    tests++; if (lsb_commit !== 1'b1 || commit_valid !== 1'b0) begin fails++; $display("FAIL store_commit: got %b/%b expected 1/0", lsb_commit, commit_valid); end
    cyc();
    tests++; if (lsb_commit !== 1'b0 || count !== 5'd0) begin fails++; $display("FAIL store_pulse: got %b/%0d expected 0/0", lsb_commit, count); end
    alloc(4, 9, 0);
    set_wb(1, 1, 32'h77, 0, 0);
    cyc(); clr_in();
    cyc();
    tests++; if (commit_valid !== 1'b1 || lsb_commit !== 1'b1 || commit_data !== 32'h77 || commit_dest !== 5'd9 || commit_tag !== 4'd1) begin fails++; $display("FAIL load_commit: got %b%b %h %0d %0d expected 11 77 9 1", commit_valid, lsb_commit, commit_data, commit_dest, commit_tag); end
  endtask

  task automatic test_rdy();
    reset_dut();
    rdy = 0; alloc_valid = 1; alloc_done = 1;
    cyc(); cyc();
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL rdy_freeze: got %0d expected 0", count); end
    rdy = 1; cyc(); alloc_valid = 0;
    tests++; if (count !== 5'd1) begin fails++; $display("FAIL rdy_resume: got %0d expected 1", count); end
  endtask

  initial begin
    cyc(); cyc();
    test_reset();
    test_fill();
    test_wrap();
    test_bypass();
    test_mispredict();
    test_store_load();
    test_rdy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
